// File: rtl/loop_sequencer.sv
// loop_sequencer: program-flow controller for the nested-loop stack.
// Fetches two-word loop descriptors from ro_data and pushes loops. Tracks
// the body start/end PC for each nesting level. Drives the loop-stack strobes
// and issues instruction PCs to the instruction queue.
//
// Ports:
//   clk, reset (async, active-low)
//   start/start_pc/halt_pc                 : run control
//   instr_is_loop/instr_desc_addr          : decode of the instruction at pc
//   rd_req/rd_addr/rd_valid/rd_data        : ro_data descriptor read port
//   queue_full, issue_valid/issue_pc       : instruction queue handshake
//   issue_copy_count                       : combinational copy of copy_count
//   should_increment, should_create_new_loop,
//   did_start_next_loop_iteration, did_finish_loop,
//   new_loop_iteration_count, new_loop_is_inner_independent_loop,
//   loop_done, copy_count                  : loop-stack interface
//   busy, error                            : status (error is sticky)
module loop_sequencer #(
  parameter int unsigned BITS                  = 18,
  parameter int unsigned PC_BITS               = 10,
  parameter int unsigned LOOP_LOG_CNT          = 3,
  parameter int unsigned SUPERSCALAR_LOG_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [PC_BITS-1:0]               start_pc,
  input  logic [PC_BITS-1:0]               halt_pc,
  input  logic                             instr_is_loop,
  input  logic [BITS-1:0]                  instr_desc_addr,
  output logic                             rd_req,
  output logic [BITS-1:0]                  rd_addr,
  input  logic                             rd_valid,
  input  logic [BITS-1:0]                  rd_data,
  input  logic                             queue_full,
  output logic                             issue_valid,
  output logic [PC_BITS-1:0]               issue_pc,
  output logic [SUPERSCALAR_LOG_WIDTH-1:0] issue_copy_count,
  output logic                             should_increment,
  output logic                             should_create_new_loop,
  output logic                             did_start_next_loop_iteration,
  output logic                             did_finish_loop,
  output logic [BITS-1:0]                  new_loop_iteration_count,
  output logic                             new_loop_is_inner_independent_loop,
  input  logic                             loop_done,
  input  logic [SUPERSCALAR_LOG_WIDTH-1:0] copy_count,
  output logic                             busy,
  output logic                             error
);

  localparam int unsigned DEPTH   = 1 << LOOP_LOG_CNT;
  localparam int unsigned DEPTH_W = LOOP_LOG_CNT + 1;
  localparam int unsigned LEN_W   = BITS - 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DESC0  = 3'd2,
    DESC1  = 3'd3,
    PUSH   = 3'd4,
    UNWIND = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [PC_BITS-1:0]   pc, pc_nxt;
  logic [DEPTH_W-1:0]   depth, depth_nxt;
  logic [LEN_W-1:0]     body_len, body_len_nxt;
  logic [PC_BITS-1:0]   start_stk [DEPTH];
  logic [PC_BITS-1:0]   end_stk   [DEPTH];

  logic                 rd_req_nxt;
  logic [BITS-1:0]      rd_addr_nxt;
  logic                 issue_valid_nxt;
  logic [PC_BITS-1:0]   issue_pc_nxt;
  logic                 inc_nxt, create_nxt, next_iter_nxt, finish_nxt;
  logic [BITS-1:0]      count_nxt;
  logic                 indep_nxt;
  logic                 error_nxt;

  logic                    push_en;
  logic [LOOP_LOG_CNT-1:0] push_idx;
  logic [LOOP_LOG_CNT-1:0] top_idx;
  logic [PC_BITS-1:0]      top_start, top_end, len_pc;
  logic                    at_top_end;
  logic                    strobe_busy;

  assign issue_copy_count = copy_count;

  assign top_idx    = LOOP_LOG_CNT'(depth - DEPTH_W'(1));
  assign push_idx   = LOOP_LOG_CNT'(depth);
  assign top_start  = start_stk[top_idx];
  assign top_end    = end_stk[top_idx];
  assign len_pc     = PC_BITS'(body_len);
  assign at_top_end = (depth != DEPTH_W'(0)) && (pc == top_end);

  // loop_done is only meaningful once the loop stack has absorbed the
  // previous jump/pop/create strobe, so end-of-body decisions wait for it.
  assign strobe_busy = did_finish_loop | did_start_next_loop_iteration | should_create_new_loop;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                              <= IDLE;
      pc                                 <= '0;
      depth                              <= '0;
      body_len                           <= '0;
      rd_req                             <= 1'b0;
      rd_addr                            <= '0;
      issue_valid                        <= 1'b0;
      issue_pc                           <= '0;
      should_increment                   <= 1'b0;
      should_create_new_loop             <= 1'b0;
      did_start_next_loop_iteration      <= 1'b0;
      did_finish_loop                    <= 1'b0;
      new_loop_iteration_count           <= '0;
      new_loop_is_inner_independent_loop <= 1'b0;
      busy                               <= 1'b0;
      error                              <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        start_stk[i] <= '0;
        end_stk[i]   <= '0;
      end
    end else begin
      state                              <= state_nxt;
      pc                                 <= pc_nxt;
      depth                              <= depth_nxt;
      body_len                           <= body_len_nxt;
      rd_req                             <= rd_req_nxt;
      rd_addr                            <= rd_addr_nxt;
      issue_valid                        <= issue_valid_nxt;
      issue_pc                           <= issue_pc_nxt;
      should_increment                   <= inc_nxt;
      should_create_new_loop             <= create_nxt;
      did_start_next_loop_iteration      <= next_iter_nxt;
      did_finish_loop                    <= finish_nxt;
      new_loop_iteration_count           <= count_nxt;
      new_loop_is_inner_independent_loop <= indep_nxt;
      busy                               <= (state_nxt != IDLE);
      error                              <= error_nxt;
      if (push_en) begin
        start_stk[push_idx] <= pc + PC_BITS'(1);
        end_stk[push_idx]   <= pc + len_pc;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    depth_nxt       = depth;
    body_len_nxt    = body_len;
    rd_req_nxt      = 1'b0;
    rd_addr_nxt     = rd_addr;
    issue_valid_nxt = 1'b0;
    issue_pc_nxt    = issue_pc;
    inc_nxt         = 1'b0;
    create_nxt      = 1'b0;
    next_iter_nxt   = 1'b0;
    finish_nxt      = 1'b0;
    count_nxt       = new_loop_iteration_count;
    indep_nxt       = new_loop_is_inner_independent_loop;
    error_nxt       = error;
    push_en         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pc_nxt    = start_pc;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (pc == halt_pc) begin
          if (depth != DEPTH_W'(0)) error_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (instr_is_loop) begin
          rd_req_nxt  = 1'b1;
          rd_addr_nxt = instr_desc_addr;
          state_nxt   = DESC0;
        end else if (!queue_full && !(at_top_end && strobe_busy)) begin
          issue_valid_nxt = 1'b1;
          issue_pc_nxt    = pc;
          inc_nxt         = 1'b1;
          if (at_top_end) begin
            if (!loop_done) begin
              next_iter_nxt = 1'b1;
              pc_nxt        = top_start;
            end else begin
              finish_nxt = 1'b1;
              depth_nxt  = depth - DEPTH_W'(1);
              state_nxt  = UNWIND;
            end
          end else begin
            pc_nxt = pc + PC_BITS'(1);
          end
        end
      end

      DESC0: begin
        if (rd_valid) begin
          count_nxt   = rd_data;
          rd_req_nxt  = 1'b1;
          rd_addr_nxt = rd_addr + BITS'(1);
          state_nxt   = DESC1;
        end
      end

      DESC1: begin
        if (rd_valid) begin
          indep_nxt    = rd_data[BITS-1];
          body_len_nxt = rd_data[BITS-2:0];
          state_nxt    = PUSH;
        end
      end

      PUSH: begin
        if (new_loop_iteration_count == BITS'(0)) begin
          // Zero-trip loop: step over the body without touching the stack
          pc_nxt    = pc + len_pc + PC_BITS'(1);
          state_nxt = RUN;
        end else if (depth == DEPTH_W'(DEPTH)) begin
          error_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (!queue_full) begin
          create_nxt = 1'b1;
          inc_nxt    = 1'b1;
          push_en    = 1'b1;
          depth_nxt  = depth + DEPTH_W'(1);
          pc_nxt     = pc + PC_BITS'(1);
          state_nxt  = RUN;
        end
      end

      UNWIND: begin
        // The popped loop's last instruction may also end enclosing loops
        if (!strobe_busy) begin
          if (at_top_end) begin
            if (!loop_done) begin
              next_iter_nxt = 1'b1;
              pc_nxt        = top_start;
              state_nxt     = RUN;
            end else begin
              finish_nxt = 1'b1;
              depth_nxt  = depth - DEPTH_W'(1);
            end
          end else begin
            pc_nxt    = pc + PC_BITS'(1);
            state_nxt = RUN;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed testbench for loop_sequencer with a small ro_data and loop-stack model.
module tb_loop_sequencer;

  localparam int unsigned BITS    = 18;
  localparam int unsigned PC_BITS = 10;
  localparam int unsigned SLW     = 2;

  logic               clk;
  logic               reset;
  logic               start;
  logic [PC_BITS-1:0] start_pc;
  logic [PC_BITS-1:0] halt_pc;
  logic               instr_is_loop;
  logic [BITS-1:0]    instr_desc_addr;
  logic               rd_req;
  logic [BITS-1:0]    rd_addr;
  logic               rd_valid;
  logic [BITS-1:0]    rd_data;
  logic               queue_full;
  logic               issue_valid;
  logic [PC_BITS-1:0] issue_pc;
  logic [SLW-1:0]     issue_copy_count;
  logic               should_increment;
  logic               should_create_new_loop;
  logic               did_start_next_loop_iteration;
  logic               did_finish_loop;
  logic [BITS-1:0]    new_loop_iteration_count;
  logic               new_loop_is_inner_independent_loop;
  logic               loop_done;
  logic [SLW-1:0]     copy_count;
  logic               busy;
  logic               error;

  loop_sequencer #(
    .BITS(BITS), .PC_BITS(PC_BITS), .LOOP_LOG_CNT(3), .SUPERSCALAR_LOG_WIDTH(SLW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .halt_pc(halt_pc),
    .instr_is_loop(instr_is_loop), .instr_desc_addr(instr_desc_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .queue_full(queue_full), .issue_valid(issue_valid), .issue_pc(issue_pc),
    .issue_copy_count(issue_copy_count), .should_increment(should_increment),
    .should_create_new_loop(should_create_new_loop),
    .did_start_next_loop_iteration(did_start_next_loop_iteration),
    .did_finish_loop(did_finish_loop),
    .new_loop_iteration_count(new_loop_iteration_count),
    .new_loop_is_inner_independent_loop(new_loop_is_inner_independent_loop),
    .loop_done(loop_done), .copy_count(copy_count), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: which PCs hold create_loop and where their descriptors live
  logic            prog_loop [1024];
  logic [BITS-1:0] prog_desc [1024];
  logic [BITS-1:0] rom       [256];

  assign instr_is_loop   = prog_loop[dut.pc];
  assign instr_desc_addr = prog_desc[dut.pc];

  int checks   = 0;
  int failures = 0;

  int iss_q[$];
  int exp_q[$];
  int n_create, n_jump, n_finish, n_rdreq, bp_bad;
  int lm_depth;
  int lm_cnt  [9];
  int lm_iter [9];
  int pend_cnt;
  int rd_lat;
  logic [7:0] pend_addr;
  logic qf_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_issues(input string tag);
    int n;
    check({tag, "_issue_cnt"}, 32'(iss_q.size()), 32'(exp_q.size()));
    n = (iss_q.size() < exp_q.size()) ? iss_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_issue%0d", tag, i), 32'(iss_q[i]), 32'(exp_q[i]));
  endtask

  // Monitor, ro_data memory and loop-stack model, evaluated just after each edge
  initial begin
    rd_valid  = 1'b0;
    rd_data   = '0;
    loop_done = 1'b0;
    forever begin
      @(posedge clk);
      qf_prev = queue_full;
      #1;
      if (issue_valid) iss_q.push_back(int'(issue_pc));
      if ((issue_valid || should_increment) && qf_prev) bp_bad++;
      if (rd_req) n_rdreq++;
      if (should_create_new_loop) begin
        n_create++;
        if (lm_depth < 9) begin
          lm_cnt[lm_depth]  = int'(new_loop_iteration_count);
          lm_iter[lm_depth] = 0;
          lm_depth++;
        end
      end
      if (did_start_next_loop_iteration) begin
        n_jump++;
        if (lm_depth > 0) lm_iter[lm_depth-1]++;
      end
      if (did_finish_loop) begin
        n_finish++;
        if (lm_depth > 0) lm_depth--;
      end
      loop_done = (lm_depth > 0) && (lm_iter[lm_depth-1] == lm_cnt[lm_depth-1] - 1);
      rd_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = rom[pend_addr];
        end
      end
      if (rd_req) begin
        pend_cnt  = rd_lat;
        pend_addr = rd_addr[7:0];
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      prog_loop[i] = 1'b0;
      prog_desc[i] = '0;
    end
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic add_loop(input int pc, input int cnt, input int len, input logic indep);
    prog_loop[pc]     = 1'b1;
    prog_desc[pc]     = BITS'(2 * pc);
    rom[2 * pc]       = BITS'(cnt);
    rom[2 * pc + 1]   = {indep, 17'(len)};
  endtask

  task automatic clear_counts();
    iss_q.delete();
    exp_q.delete();
    n_create = 0; n_jump = 0; n_finish = 0; n_rdreq = 0; bp_bad = 0;
    lm_depth = 0;
    for (int i = 0; i < 9; i++) begin
      lm_cnt[i]  = 0;
      lm_iter[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    pend_cnt = 0;
    clear_counts();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_prog(input string tag, input int spc, input int hpc);
    @(negedge clk);
    start_pc = PC_BITS'(spc);
    halt_pc  = PC_BITS'(hpc);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic single_loop_test(input string tag);
    clear_prog();
    add_loop(0, 3, 2, 1'b0);
    run_prog(tag, 0, 3);
    exp_q = '{1, 2, 1, 2, 1, 2};
    check_issues(tag);
    check({tag, "_jumps"}, 32'(n_jump), 32'd2);
    check({tag, "_finish"}, 32'(n_finish), 32'd1);
    check({tag, "_create"}, 32'(n_create), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    start_pc   = '0;
    halt_pc    = '0;
    queue_full = 1'b0;
    copy_count = 2'd2;
    rd_lat     = 1;
    pend_cnt   = 0;
    clear_prog();
    clear_counts();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_strobes", 32'({should_increment, should_create_new_loop,
                              did_start_next_loop_iteration, did_finish_loop}), 32'd0);
    check("copy_count_pass", 32'(issue_copy_count), 32'd2);
    reset = 1'b1;
    @(negedge clk);

    single_loop_test("single");

    // Inner and outer loop bodies both end at pc 2
    do_reset();
    clear_prog();
    add_loop(0, 2, 2, 1'b0);
    add_loop(1, 2, 1, 1'b1);
    run_prog("nested", 0, 3);
    exp_q = '{2, 2, 2, 2};
    check_issues("nested");
    check("nested_create", 32'(n_create), 32'd3);
    check("nested_jumps", 32'(n_jump), 32'd3);
    check("nested_finish", 32'(n_finish), 32'd3);
    check("nested_depth", 32'(lm_depth), 32'd0);
    check("nested_error", 32'(error), 32'd0);

    // Backpressure for 5 cycles in the middle of the body
    do_reset();
    clear_prog();
    add_loop(0, 2, 4, 1'b0);
    @(negedge clk);
    start_pc = '0;
    halt_pc  = PC_BITS'(5);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    for (int i = 0; i < 200 && iss_q.size() < 2; i++) @(negedge clk);
    check("bp_reached", 32'(iss_q.size()), 32'd2);
    queue_full = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_frozen", 32'(iss_q.size()), 32'd2);
    queue_full = 1'b0;
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("bp_idle", 32'(busy), 32'd0);
    exp_q = '{1, 2, 3, 4, 1, 2, 3, 4};
    check_issues("bp");
    check("bp_no_issue_when_full", 32'(bp_bad), 32'd0);
    check("bp_finish", 32'(n_finish), 32'd1);

    // Zero-trip loop skips its body
    do_reset();
    clear_prog();
    add_loop(5, 0, 4, 1'b0);
    run_prog("zero", 5, 11);
    exp_q = '{10};
    check_issues("zero");
    check("zero_create", 32'(n_create), 32'd0);

    // Nine nested loops overflow the 8-deep stack
    do_reset();
    clear_prog();
    for (int i = 0; i < 9; i++) add_loop(i, 1, 30 - i, 1'b0);
    run_prog("ovf", 0, 100);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_create", 32'(n_create), 32'd8);
    check("ovf_issues", 32'(iss_q.size()), 32'd0);

    // Async reset while waiting on the second descriptor word
    do_reset();
    clear_prog();
    add_loop(0, 3, 2, 1'b0);
    rd_lat = 4;
    @(negedge clk);
    start_pc = '0;
    halt_pc  = PC_BITS'(3);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    for (int i = 0; i < 200 && n_rdreq < 2; i++) @(negedge clk);
    check("ar_in_desc1", 32'(n_rdreq), 32'd2);
    reset = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_rd_req", 32'(rd_req), 32'd0);
    check("ar_rd_addr", 32'(rd_addr), 32'd0);
    check("ar_issue_valid", 32'(issue_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("ar_late_valid_ignored", 32'(busy), 32'd0);
    check("ar_no_req", 32'(n_rdreq), 32'd2);
    check("ar_error", 32'(error), 32'd0);
    rd_lat = 1;
    clear_counts();
    single_loop_test("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
